// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter sequencer.
package pc_pkg;

  // Sequencer state encoding, also visible on the state output.
  typedef enum logic [1:0] {
    PC_BOOT = 2'd0,
    PC_RUN  = 2'd1,
    PC_HALT = 2'd2
  } pc_state_e;

  // Default vectors for a 32-bit address space.
  localparam logic [31:0] PC_RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VECTOR_DEF   = 32'h8000_0180;

  // Mask that clears the low log2(instr_bytes) address bits; instr_bytes
  // is a power of two, so (instr_bytes - 1) is exactly the offset field.
  function automatic logic [63:0] align_mask(input int unsigned instr_bytes);
    return ~(64'(instr_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: boot hold, fetch handshake, redirect and
// exception vectoring with EPC capture, and a halt/resume state machine.
//
// Handshake: pc_valid is the valid, fetch_ready the ready. An address is
// consumed when both are high at a rising edge; until then PCResult stays
// stable unless a redirect or exception replaces it (a flush beats a stall).
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR_DEF),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(PC_EXC_VECTOR_DEF),
  parameter int               INSTR_BYTES  = 4,
  parameter int               BOOT_CYCLES  = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             PCWrite,
  input  logic             fetch_ready,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_valid,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             halt_req,
  input  logic             resume,
  output logic [WIDTH-1:0] PCResult,
  output logic             pc_valid,
  output logic [WIDTH-1:0] epc,
  output logic [1:0]       state
);

  localparam logic [1:0] ST_BOOT = PC_BOOT;
  localparam logic [1:0] ST_RUN  = PC_RUN;
  localparam logic [1:0] ST_HALT = PC_HALT;

  localparam int               CNT_W      = $clog2(BOOT_CYCLES + 1);
  localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [WIDTH-1:0] PC_INC     = WIDTH'(INSTR_BYTES);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(align_mask(INSTR_BYTES));

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state and next-PC selection with the per-state priority order.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_BOOT: begin
        // Control inputs are ignored while the boot counter runs out.
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (exc_valid) begin
          pc_d  = EXC_VECTOR;
          epc_d = exc_pc;
        end else if (redirect_valid) begin
          pc_d = redirect_target & ALIGN_MASK;
        end else if (halt_req) begin
          state_d = ST_HALT;
        end else if (PCWrite && fetch_ready) begin
          pc_d = pc_q + PC_INC;  // wraps modulo 2^WIDTH
        end
      end
      ST_HALT: begin
        // An exception wakes the core; a redirect only retargets it.
        if (exc_valid) begin
          pc_d    = EXC_VECTOR;
          epc_d   = exc_pc;
          state_d = ST_RUN;
        end else if (redirect_valid) begin
          pc_d = redirect_target & ALIGN_MASK;
        end else if (resume) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        // Unused encoding: restart the boot sequence.
        state_d = ST_BOOT;
        cnt_d   = '0;
        pc_d    = RESET_VECTOR;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PCResult = pc_q;
  assign epc      = epc_q;
  assign state    = state_q;
  assign pc_valid = (state_q == ST_RUN);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: 32-bit default instance plus an 8-bit
// instance for address wrap. Drivers push expected observations into a
// queue; a negedge monitor pops and compares them.
module tb_pc_sequencer;

  localparam int OBS_W = 68;  // {sel, state[1:0], pc_valid, pc[31:0], epc[31:0]}

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // 32-bit DUT controls
  logic        pcwrite = 1'b0, fready = 1'b0, rv = 1'b0, exc = 1'b0;
  logic        halt = 1'b0, res = 1'b0;
  logic [31:0] tgt = '0, excpc = '0;
  logic [31:0] pc_o, epc_o;
  logic        v_o;
  logic [1:0]  st_o;

  // 8-bit DUT controls
  logic        pcwrite8 = 1'b0, fready8 = 1'b0, rv8 = 1'b0;
  logic [7:0]  tgt8 = '0;
  logic [7:0]  pc8_o, epc8_o;
  logic        v8_o;
  logic [1:0]  st8_o;

  logic [OBS_W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  localparam logic [1:0] BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2;

  // Clock and reset
  always #5 clk = ~clk;

  pc_sequencer dut (
    .Clk(clk), .Reset(rst_n), .PCWrite(pcwrite), .fetch_ready(fready),
    .redirect_valid(rv), .redirect_target(tgt), .exc_valid(exc), .exc_pc(excpc),
    .halt_req(halt), .resume(res), .PCResult(pc_o), .pc_valid(v_o),
    .epc(epc_o), .state(st_o)
  );

  pc_sequencer #(
    .WIDTH(8), .RESET_VECTOR(8'h00), .EXC_VECTOR(8'h80),
    .INSTR_BYTES(4), .BOOT_CYCLES(2)
  ) dut8 (
    .Clk(clk), .Reset(rst_n), .PCWrite(pcwrite8), .fetch_ready(fready8),
    .redirect_valid(rv8), .redirect_target(tgt8), .exc_valid(1'b0), .exc_pc(8'h00),
    .halt_req(1'b0), .resume(1'b0), .PCResult(pc8_o), .pc_valid(v8_o),
    .epc(epc8_o), .state(st8_o)
  );

  // Driver tasks: inputs are already set; after the edge, record what the
  // DUT must show, then return at the following negedge.
  task automatic step(input logic [1:0] st, input logic v,
                      input logic [31:0] pc, input logic [31:0] ep);
    @(posedge clk);
    exp_q.push_back({1'b0, st, v, pc, ep});
    @(negedge clk);
  endtask

  task automatic step8(input logic [1:0] st, input logic v, input logic [7:0] pc);
    @(posedge clk);
    exp_q.push_back({1'b1, st, v, 24'h0, pc, 32'h0});
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    pcwrite = 1'b0; fready = 1'b0; rv = 1'b0; exc = 1'b0; halt = 1'b0; res = 1'b0;
    tgt = '0; excpc = '0;
  endtask

  // Scoreboard monitor: compares each queued expectation at the negedge.
  always @(negedge clk) begin
    logic [OBS_W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[67]) a = {1'b1, st8_o, v8_o, 24'h0, pc8_o, 24'h0, epc8_o};
      else       a = {1'b0, st_o, v_o, pc_o, epc_o};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL vec%0d dut%0s: got st=%0d v=%0b pc=%h epc=%h, want st=%0d v=%0b pc=%h epc=%h",
                 vectors, e[67] ? "8" : "32", a[66:65], a[64], a[63:32], a[31:0],
                 e[66:65], e[64], e[63:32], e[31:0]);
      end
    end
  end

  initial begin
    // Reset state
    idle_inputs();
    step(BOOT, 0, 32'h0, 32'h0);
    step(BOOT, 0, 32'h0, 32'h0);

    // Reset release: two boot cycles, then sequential fetch
    rst_n = 1'b1; pcwrite = 1'b1; fready = 1'b1;
    step(BOOT, 0, 32'h0, 32'h0);
    step(RUN,  1, 32'h0, 32'h0);
    step(RUN,  1, 32'h4, 32'h0);
    step(RUN,  1, 32'h8, 32'h0);
    step(RUN,  1, 32'hC, 32'h0);

    // Stall and handshake at 0x10
    rv = 1'b1; tgt = 32'h10;
    step(RUN, 1, 32'h10, 32'h0);
    rv = 1'b0; pcwrite = 1'b0;
    repeat (3) step(RUN, 1, 32'h10, 32'h0);
    pcwrite = 1'b1; fready = 1'b0;
    repeat (2) step(RUN, 1, 32'h10, 32'h0);
    fready = 1'b1;
    step(RUN, 1, 32'h14, 32'h0);

    // Redirect during stall (aligned), then back-to-back redirect
    pcwrite = 1'b0; rv = 1'b1; tgt = 32'h103;
    step(RUN, 1, 32'h100, 32'h0);
    tgt = 32'h40;
    step(RUN, 1, 32'h40, 32'h0);

    // Exception beats redirect
    exc = 1'b1; excpc = 32'h3C; tgt = 32'h200;
    step(RUN, 1, 32'h8000_0180, 32'h3C);
    exc = 1'b0; rv = 1'b0; pcwrite = 1'b1;
    step(RUN, 1, 32'h8000_0184, 32'h3C);

    // Halt / redirect while halted / resume
    rv = 1'b1; tgt = 32'h20;
    step(RUN, 1, 32'h20, 32'h3C);
    rv = 1'b0; halt = 1'b1;
    step(HALT, 0, 32'h20, 32'h3C);
    step(HALT, 0, 32'h20, 32'h3C);
    halt = 1'b0; rv = 1'b1; tgt = 32'h300;
    step(HALT, 0, 32'h300, 32'h3C);
    rv = 1'b0; res = 1'b1;
    step(RUN, 1, 32'h300, 32'h3C);
    res = 1'b0;
    step(RUN, 1, 32'h304, 32'h3C);

    // Exception together with resume while halted
    halt = 1'b1;
    step(HALT, 0, 32'h304, 32'h3C);
    halt = 1'b0; exc = 1'b1; excpc = 32'h1234; res = 1'b1;
    step(RUN, 1, 32'h8000_0180, 32'h1234);
    exc = 1'b0; res = 1'b0;
    step(RUN, 1, 32'h8000_0184, 32'h1234);

    // 32-bit wrap
    rv = 1'b1; tgt = 32'hFFFF_FFFF;
    step(RUN, 1, 32'hFFFF_FFFC, 32'h1234);
    rv = 1'b0;
    step(RUN, 1, 32'h0, 32'h1234);

    // Asynchronous reset mid-cycle aborts a pending redirect
    rv = 1'b1; tgt = 32'h500;
    #2 rst_n = 1'b0;
    exp_q.push_back({1'b0, BOOT, 1'b0, 32'h0, 32'h0});
    @(negedge clk);
    idle_inputs();
    step(BOOT, 0, 32'h0, 32'h0);
    rst_n = 1'b1;
    step(BOOT, 0, 32'h0, 32'h0);
    step(RUN,  1, 32'h0, 32'h0);

    // 8-bit instance: aligned redirect, advance with wrap
    rv8 = 1'b1; tgt8 = 8'hFF;
    step8(RUN, 1, 8'hFC);
    rv8 = 1'b0; pcwrite8 = 1'b1; fready8 = 1'b1;
    step8(RUN, 1, 8'h00);
    step8(RUN, 1, 8'h04);

    // Drain the scoreboard with a bounded wait
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised next-generation program counter for the fetch stage. Beyond the basic hold/load register, it adds a boot-hold phase, a fetch-ready handshake, redirect and exception vectoring with EPC capture, and a halt/resume state machine. Its output address drives instruction memory. Its control inputs come from the hazard unit (stall), branch/jump resolution (redirect) and exception logic.

## Interface
Parameters:
- WIDTH, 32, address width in bits.
- RESET_VECTOR, 32'h00000000, PC value on reset.
- EXC_VECTOR, 32'h80000180, PC loaded on exception.
- INSTR_BYTES, 4, sequential increment; power of two, at least 1.
- BOOT_CYCLES, 2, cycles held in BOOT after reset release; at least 1.

Ports:
- Clk  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- PCWrite  in  1  1 = PC may advance; 0 = stall (hold).
- fetch_ready  in  1  fetch accepts the current address this cycle.
- redirect_valid  in  1  branch/jump taken.
- redirect_target  in  WIDTH  redirect address.
- exc_valid  in  1  exception request.
- exc_pc  in  WIDTH  address of the faulting instruction.
- halt_req  in  1  request halt.
- resume  in  1  leave halt.
- PCResult  out  WIDTH  current fetch address.
- pc_valid  out  1  PCResult is a valid fetch request.
- epc  out  WIDTH  last captured exception PC.
- state  out  2  BOOT=0, RUN=1, HALT=2.

## Operation
- Reset (Reset=0, asynchronous) sets:
  - PCResult=RESET_VECTOR, epc=0, state=BOOT, boot counter=0.
  - pc_valid=0.
- BOOT:
  - The counter increments each cycle; all control inputs are ignored.
  - When the counter reaches BOOT_CYCLES-1, the next state is RUN.
  - PCResult stays at RESET_VECTOR.
- RUN has the following priority per cycle; only one action is taken:
  1. exc_valid: PCResult<=EXC_VECTOR and epc<=exc_pc.
  2. redirect_valid: PCResult<=redirect_target with the low log2(INSTR_BYTES) bits forced to 0.
  3. halt_req: state<=HALT and PCResult holds.
  4. Advance when PCWrite=1 and fetch_ready=1: PCResult<=PCResult+INSTR_BYTES, modulo 2^WIDTH (it wraps with no flag).
  5. Otherwise, hold.
- Redirect and exception override both PCWrite=0 and fetch_ready=0; a flush beats a stall.
- HALT:
  - pc_valid=0 and PCResult holds.
  - exc_valid: same loads as in RUN, and state<=RUN (wake on exception).
  - redirect_valid: loads the target and the state stays HALT.
  - resume: state<=RUN.
  - halt_req is ignored.
  - If exc_valid and resume arrive together, the exception is applied once and state<=RUN.
- pc_valid = (state==RUN). It is combinational from the state register and is never asserted in BOOT or HALT.
- epc changes only on an accepted exception.

## Timing
- All state updates occur on the rising edge of Clk; every registered output has 1-cycle latency from its inputs.
- The first pc_valid=1 occurs BOOT_CYCLES rising edges after Reset deasserts, with PCResult=RESET_VECTOR.
- Handshake: an address is consumed when pc_valid and fetch_ready are both high at a rising edge. The address is held stable until it is consumed, unless it is redirected or an exception is taken.
- Reset asserted mid-operation forces reset values immediately (asynchronously), including an abort of any pending redirect.
- Back-to-back redirects are each honoured in consecutive cycles.

## Structure
- Shared package pc_pkg holds:
  - the state enumeration (BOOT/RUN/HALT, 2 bits);
  - default RESET_VECTOR and EXC_VECTOR constants;
  - the alignment-mask helper function.
- The block is a single module with no sub-module. The boot counter is sized $clog2(BOOT_CYCLES+1).

## Test plan
- Reset release with BOOT_CYCLES=2, PCWrite=1, fetch_ready=1:
  - state is BOOT for 2 cycles, then RUN;
  - pc_valid first rises with PCResult=0x0;
  - subsequent values are 0x4, 0x8, 0xC.
- Stall and handshake: in RUN at PC=0x10, hold PCWrite=0 for 3 cycles, then fetch_ready=0 for 2 cycles → PCResult stays 0x10 throughout; it advances to 0x14 when both are high.
- Redirect during stall: PCWrite=0, redirect_valid=1, target 0x103 → PCResult=0x100 the next cycle.
- Exception priority at PC=0x40 with exc_valid=1, exc_pc=0x3C, redirect_valid=1, target 0x200 → PCResult=0x80000180 and epc=0x3C; the redirect is discarded.
- Halt/resume:
  - halt_req at PC=0x20 → HALT, pc_valid=0, PC holds at 0x20;
  - redirect to 0x300 while halted → PC=0x300, still HALT;
  - resume → RUN, pc_valid=1 at 0x300.
- Wrap and async reset:
  - WIDTH=8, PC=0xFC, advance → 0x00;
  - assert Reset mid-cycle → PCResult=RESET_VECTOR and state=BOOT before the next edge.
